// File: rtl/cordic_iter.sv
// Iterative CORDIC engine: one micro-rotation per clock, rotation and vectoring
// modes, valid/ready on both sides, saturated x/y results.
module cordic_iter #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned ITERS = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic             mode_i,
  input  logic [WIDTH-1:0] x_i,
  input  logic [WIDTH-1:0] y_i,
  input  logic [WIDTH:0]   z_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] x_o,
  output logic [WIDTH-1:0] y_o,
  output logic [WIDTH:0]   z_o,
  output logic             busy_o
);

  localparam int unsigned FRAC = WIDTH - 2;
  localparam int unsigned XW   = WIDTH + 2;
  localparam int unsigned ZW   = WIDTH + 1;
  localparam int unsigned TW   = ZW + 2;
  localparam int unsigned IW   = $clog2(ITERS);
  localparam real         PI_R = 3.14159265358979323846;

  typedef logic [ITERS-1:0][ZW-1:0] atan_tab_t;

  function automatic real pow2(input int n);
    real r;
    r = 1.0;
    for (int k = 0; k < n; k++) r = r * 2.0;
    return r;
  endfunction

  // Taylor series; only called with t <= 0.5 where it converges quickly
  function automatic real atan_series(input real t);
    real sum;
    real term;
    sum  = 0.0;
    term = t;
    for (int k = 0; k < 60; k++) begin
      if ((k % 2) == 0) sum = sum + term / real'(2 * k + 1);
      else              sum = sum - term / real'(2 * k + 1);
      term = term * t * t;
    end
    return sum;
  endfunction

  function automatic atan_tab_t build_atan();
    atan_tab_t tab;
    real       a;
    for (int k = 0; k < int'(ITERS); k++) begin
      a      = (k == 0) ? PI_R / 4.0 : atan_series(1.0 / pow2(k));
      tab[k] = ZW'($rtoi(a * pow2(int'(FRAC)) + 0.5));
    end
    return tab;
  endfunction

  localparam int                   PI_I    = $rtoi(PI_R * pow2(int'(FRAC)) + 0.5);
  localparam logic signed [TW-1:0] PI      = TW'(PI_I);
  localparam logic signed [TW-1:0] HALF_PI = TW'(PI_I / 2);
  localparam logic signed [TW-1:0] TWO_PI  = TW'(2 * PI_I);
  localparam atan_tab_t            ATAN    = build_atan();
  localparam logic signed [XW-1:0] SAT_MAX = XW'((1 << (WIDTH - 1)) - 1);
  localparam logic signed [XW-1:0] SAT_MIN = XW'(-(1 << (WIDTH - 1)));

  function automatic logic [WIDTH-1:0] sat(input logic signed [XW-1:0] v);
    if (v > SAT_MAX) return SAT_MAX[WIDTH-1:0];
    if (v < SAT_MIN) return SAT_MIN[WIDTH-1:0];
    return v[WIDTH-1:0];
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_PRE, S_ITER, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic signed [XW-1:0]   x_q, x_d, y_q, y_d;
  logic signed [ZW-1:0]   z_q, z_d;
  logic        [IW-1:0]   i_q, i_d;
  logic                   mode_q, mode_d;
  logic        [WIDTH-1:0] xo_q, xo_d, yo_q, yo_d;
  logic        [ZW-1:0]   zo_q, zo_d;
  logic                   valid_q, busy_q;
  logic                   accept;
  logic                   last_iter;
  logic signed [TW-1:0]   zt;
  logic signed [XW-1:0]   xs, ys;
  logic signed [ZW-1:0]   atan_k;
  logic                   dir;

  assign accept    = in_valid_i & in_ready_o;
  assign last_iter = (i_q == IW'(ITERS - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (in_valid_i) state_d = S_PRE;
      S_PRE:  state_d = S_ITER;
      S_ITER: if (last_iter) state_d = S_DONE;
      S_DONE: if (out_ready_i) state_d = in_valid_i ? S_PRE : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake output, combinational from state and consumer ready
  always_comb begin
    in_ready_o = 1'b0;
    case (state_q)
      S_IDLE:  in_ready_o = 1'b1;
      S_DONE:  in_ready_o = out_ready_i;
      default: in_ready_o = 1'b0;
    endcase
  end

  // Datapath next-state: operand latch, range reduction, micro-rotation
  always_comb begin
    x_d    = x_q;
    y_d    = y_q;
    z_d    = z_q;
    i_d    = i_q;
    mode_d = mode_q;
    xo_d   = xo_q;
    yo_d   = yo_q;
    zo_d   = zo_q;
    zt     = TW'(z_q);
    xs     = x_q >>> i_q;
    ys     = y_q >>> i_q;
    atan_k = ATAN[i_q];
    dir    = mode_q ? y_q[XW-1] : ~z_q[ZW-1];

    if (accept) begin
      x_d    = XW'($signed(x_i));
      y_d    = XW'($signed(y_i));
      z_d    = $signed(z_i);
      mode_d = mode_i;
    end else if (state_q == S_PRE) begin
      if (!mode_q) begin
        if (zt > PI)       zt = zt - TWO_PI;
        else if (zt < -PI) zt = zt + TWO_PI;
        if (zt > HALF_PI) begin
          x_d = -y_q;
          y_d = x_q;
          zt  = zt - HALF_PI;
        end else if (zt < -HALF_PI) begin
          x_d = y_q;
          y_d = -x_q;
          zt  = zt + HALF_PI;
        end
      end else if (x_q[XW-1]) begin
        x_d = -x_q;
        y_d = -y_q;
        zt  = y_q[XW-1] ? zt - PI : zt + PI;
        if (zt > PI)       zt = zt - TWO_PI;
        else if (zt < -PI) zt = zt + TWO_PI;
      end
      z_d = ZW'(zt);
      i_d = '0;
    end else if (state_q == S_ITER) begin
      if (dir) begin
        x_d = x_q - ys;
        y_d = y_q + xs;
        z_d = z_q - atan_k;
      end else begin
        x_d = x_q + ys;
        y_d = y_q - xs;
        z_d = z_q + atan_k;
      end
      i_d = i_q + IW'(1);
      if (last_iter) begin
        xo_d = sat(x_d);
        yo_d = sat(y_d);
        zo_d = z_d;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      i_q     <= '0;
      mode_q  <= 1'b0;
      xo_q    <= '0;
      yo_q    <= '0;
      zo_q    <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      i_q     <= i_d;
      mode_q  <= mode_d;
      xo_q    <= xo_d;
      yo_q    <= yo_d;
      zo_q    <= zo_d;
      valid_q <= (state_d == S_DONE);
      busy_q  <= (state_d != S_IDLE);
    end
  end

  assign x_o         = xo_q;
  assign y_o         = yo_q;
  assign z_o         = zo_q;
  assign out_valid_o = valid_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_cordic_iter.sv
// Directed bench for cordic_iter at WIDTH=16/ITERS=16 with hand-derived expectations.
module tb_cordic_iter;

  localparam int W    = 16;
  localparam int IT   = 16;
  localparam int TOL  = 8;
  localparam int ZTOL = 16;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic                mode = 1'b0;
  logic signed [W-1:0] x_i = '0;
  logic signed [W-1:0] y_i = '0;
  logic signed [W:0]   z_i = '0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic signed [W-1:0] x_o, y_o;
  logic signed [W:0]   z_o;
  logic                busy;

  int total  = 0;
  int passed = 0;
  int lat;
  int hx, hy, hz;

  cordic_iter #(.WIDTH(W), .ITERS(IT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .mode_i     (mode),
    .x_i        (x_i),
    .y_i        (y_i),
    .z_i        (z_i),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .x_o        (x_o),
    .y_o        (y_o),
    .z_o        (z_o),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic chk_near(input string tag, input longint obs, input longint exp,
                          input longint tol);
    logic ok;
    ok = ((obs - exp) <= tol) && ((exp - obs) <= tol);
    total++;
    assert (ok === 1'b1) passed++;
    else $error("FAIL %s: observed %0d expected %0d +/- %0d", tag, obs, exp, tol);
  endtask

  // Present one operand set for a single accepting edge, then scramble the inputs
  task automatic start_op(input logic m, input int x, input int y, input int z);
    @(negedge clk);
    mode     = m;
    x_i      = W'(x);
    y_i      = W'(y);
    z_i      = (W+1)'(z);
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    mode     = ~m;
    x_i      = W'($urandom);
    y_i      = W'($urandom);
    z_i      = (W+1)'($urandom);
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic pop();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_x_out", x_o, 0);
    @(negedge clk);
    rst_n = 1'b1;

    // sin/cos of pi/4
    start_op(1'b0, 'h26DD, 0, 'h3244);
    chk("busy_after_accept", busy, 1);
    wait_valid(lat);
    chk("rot45_latency", lat, IT + 1);
    chk_near("rot45_x", x_o, 11585, TOL);
    chk_near("rot45_y", y_o, 11585, TOL);
    chk_near("rot45_z", z_o, 0, ZTOL);
    pop();
    chk("pop_out_valid", out_valid, 0);

    // pi/2 boundary
    start_op(1'b0, 'h26DD, 0, 'h6488);
    wait_valid(lat);
    chk_near("rot90_x", x_o, 0, TOL);
    chk_near("rot90_y", y_o, 16384, TOL);
    pop();

    // +3.5 rad: wrap by 2*pi then quadrant fold
    start_op(1'b0, 'h26DD, 0, 'h0E000);
    wait_valid(lat);
    chk_near("rotwrap_x", x_o, -15343, TOL);
    chk_near("rotwrap_y", y_o, -5747, TOL);
    pop();

    // Vectoring of (0.5, 0.5)
    start_op(1'b1, 'h2000, 'h2000, 0);
    wait_valid(lat);
    chk_near("vec45_x", x_o, 19078, TOL);
    chk_near("vec45_y", y_o, 0, TOL);
    chk_near("vec45_z", z_o, 12868, ZTOL);

    // Hold the result with out_ready low
    hx = x_o;
    hy = y_o;
    hz = z_o;
    repeat (10) @(posedge clk);
    #1;
    chk("hold_x", x_o, hx);
    chk("hold_y", y_o, hy);
    chk("hold_z", z_o, hz);
    chk("hold_in_ready", in_ready, 0);
    chk("hold_out_valid", out_valid, 1);

    // Back-to-back: release and accept in the same cycle
    @(negedge clk);
    mode      = 1'b0;
    x_i       = W'('h26DD);
    y_i       = '0;
    z_i       = (W+1)'('h3244);
    in_valid  = 1'b1;
    out_ready = 1'b1;
    #1;
    chk("b2b_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("b2b_valid_drop", out_valid, 0);
    wait_valid(lat);
    chk("b2b_latency", lat, IT + 1);
    chk_near("b2b_x", x_o, 11585, TOL);
    chk_near("b2b_y", y_o, 11585, TOL);
    pop();

    // Vectoring of (-1, 0): magnitude and angle near pi
    start_op(1'b1, -'h4000, 0, 0);
    wait_valid(lat);
    chk_near("vec180_x", x_o, 26981, TOL);
    chk_near("vec180_y", y_o, 0, TOL);
    chk_near("vec180_absz", (z_o < 0) ? -int'(z_o) : int'(z_o), 51472, ZTOL);
    pop();

    // Saturation
    start_op(1'b0, 'h7FFF, 'h7FFF, 0);
    wait_valid(lat);
    chk("sat_x", x_o, 32767);
    chk("sat_y", y_o, 32767);
    pop();

    // Reset mid-ITER at i=5, with an input offered while reset is low
    start_op(1'b0, 'h26DD, 0, 'h3244);
    repeat (6) @(posedge clk);
    #2;
    rst_n    = 1'b0;
    in_valid = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_x_out", x_o, 0);
    chk("midrst_z_out", z_o, 0);
    chk("midrst_in_ready", in_ready, 1);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n    = 1'b1;
    @(posedge clk);
    #1;
    chk("postrst_idle", busy, 0);

    start_op(1'b0, 'h26DD, 0, 'h3244);
    wait_valid(lat);
    chk("postrst_latency", lat, IT + 1);
    chk_near("postrst_x", x_o, 11585, TOL);
    chk_near("postrst_y", y_o, 11585, TOL);
    pop();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
